// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32 byte/half/word requests into word-aligned bus accesses and formats load data.
// Optional define LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wstrobe,
    output logic        mem_rstrobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             we_q;
    logic [CNT_W-1:0] to_cnt;

    logic             req_illegal_c;
    logic             req_misalign_c;
    logic             timeout_hit_c;

    // Store lane replication: byte/half copied into every lane it may land in.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   store_mask = 4'b0001 << lo;
            2'b01:   store_mask = 4'b0011 << {lo[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase
    endfunction

    // Right-justify the addressed lane, then sign- or zero-extend by funct3.
    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
        logic [1:0]  sh;
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   sh = lo;
            2'b01:   sh = {lo[1], 1'b0};
            default: sh = 2'b00;
        endcase
        w = word >> {sh, 3'b000};
        case (f3)
            3'b000:  load_fmt = {{24{w[7]}}, w[7:0]};
            3'b100:  load_fmt = {24'd0, w[7:0]};
            3'b001:  load_fmt = {{16{w[15]}}, w[15:0]};
            3'b101:  load_fmt = {16'd0, w[15:0]};
            default: load_fmt = w;
        endcase
    endfunction

    assign req_illegal_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                           (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign req_misalign_c = 1'b0;
`endif

    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal_c || req_misalign_c) state_nxt = RESP;
                    else                                  state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_done || timeout_hit_c) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and request context, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            mem_wstrobe <= 1'b0;
            mem_rstrobe <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            we_q        <= 1'b0;
            to_cnt      <= '0;
        end else begin
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);

            if (state == IDLE && req_valid) begin
                funct3_q  <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                we_q      <= req_we;
            end

            if (state == IDLE && state_nxt == ACCESS) begin
                mem_addr    <= {req_addr[31:2], 2'b00};
                mem_wdata   <= req_we ? store_data(req_funct3[1:0], req_wdata) : '0;
                mem_wmask   <= req_we ? store_mask(req_funct3[1:0], req_addr[1:0]) : 4'b0000;
                mem_wstrobe <= req_we;
                mem_rstrobe <= !req_we;
                to_cnt      <= '0;
            end else if (state == ACCESS && state_nxt == ACCESS) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end else begin
                mem_addr    <= '0;
                mem_wdata   <= '0;
                mem_wmask   <= 4'b0000;
                mem_wstrobe <= 1'b0;
                mem_rstrobe <= 1'b0;
            end

            if (state_nxt == RESP && state != RESP) begin
                resp_err   <= !(state == ACCESS && mem_done);
                resp_rdata <= (state == ACCESS && mem_done && !we_q)
                              ? load_fmt(funct3_q, addr_lo_q, mem_rdata) : '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single transactions plus reset and timeout sequences.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrobe;
    logic        mem_rstrobe;
    logic [31:0] mem_rdata;
    logic        mem_done;

    int          lat_cfg;
    int          wait_ctr;
    int          pass_cnt;
    int          total_cnt;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: completes after lat_cfg wait cycles of a held strobe.
    assign mem_done = (mem_rstrobe || mem_wstrobe) && (wait_ctr >= lat_cfg);
    always @(posedge clk) begin
        if ((mem_rstrobe || mem_wstrobe) && !mem_done) wait_ctr <= wait_ctr + 1;
        else                                            wait_ctr <= 0;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        int          rlat;
        int          nstb;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             pass_cnt++;
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] word, input int lat,
                                input logic err, input logic [31:0] rdata, input logic [31:0] maddr,
                                input logic [3:0] mask, input logic [31:0] mwdata,
                                input int rlat, input int nstb);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.word = word; v.lat = lat;
        v.err = err; v.rdata = rdata; v.maddr = maddr; v.mask = mask; v.mwdata = mwdata;
        v.rlat = rlat; v.nstb = nstb;
        return v;
    endfunction

    // Entered and left at a negedge with the unit idle.
    task automatic run(input int idx, input vec_t v);
        int          cyc;
        int          nstb;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_mask;
        string       tag;
        tag = $sformatf("v%0d", idx);
        chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
        lat_cfg    = v.lat;
        mem_rdata  = v.word;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc  = 1;
        nstb = 0;
        s_addr = '0; s_wdata = '0; s_mask = '0;
        while (!resp_valid && cyc < 20) begin
            if (mem_rstrobe || mem_wstrobe) begin
                if (nstb == 0) begin
                    s_addr = mem_addr; s_wdata = mem_wdata; s_mask = mem_wmask;
                end
                nstb++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " resp_cycle"}, 32'(cyc), 32'(v.rlat));
        chk({tag, " resp_err"}, 32'(resp_err), 32'(v.err));
        chk({tag, " resp_rdata"}, resp_rdata, v.rdata);
        chk({tag, " strobe_cycles"}, 32'(nstb), 32'(v.nstb));
        if (v.nstb > 0) begin
            chk({tag, " mem_addr"}, s_addr, v.maddr);
            chk({tag, " mem_wmask"}, 32'(s_mask), 32'(v.mask));
            if (v.we) chk({tag, " mem_wdata"}, s_wdata, v.mwdata);
        end
        @(negedge clk);
        chk({tag, " resp_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int   seen;
        vec_t v;
        pass_cnt = 0; total_cnt = 0;
        lat_cfg = 0; wait_ctr = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;

        //            we f3     addr   wdata         word          lat err rdata         maddr  mask     mwdata        rl nstb
        vecs[0]  = mk(1, 3'b000, 32'h06, 32'h000000AB, 32'h0,        0, 0, 32'h0,        32'h04, 4'b0100, 32'hABABABAB, 2, 1);
        vecs[1]  = mk(0, 3'b000, 32'h13, 32'h0,        32'h80F07F01, 0, 0, 32'hFFFFFF80, 32'h10, 4'b0000, 32'h0,        2, 1);
        vecs[2]  = mk(0, 3'b100, 32'h13, 32'h0,        32'h80F07F01, 0, 0, 32'h00000080, 32'h10, 4'b0000, 32'h0,        2, 1);
        vecs[3]  = mk(0, 3'b001, 32'h12, 32'h0,        32'h80F07F01, 0, 0, 32'hFFFF80F0, 32'h10, 4'b0000, 32'h0,        2, 1);
        vecs[4]  = mk(0, 3'b010, 32'h10, 32'h0,        32'h80F07F01, 0, 0, 32'h80F07F01, 32'h10, 4'b0000, 32'h0,        2, 1);
        vecs[5]  = mk(0, 3'b101, 32'h10, 32'h0,        32'h80F07F01, 1, 0, 32'h00007F01, 32'h10, 4'b0000, 32'h0,        3, 2);
        vecs[6]  = mk(0, 3'b000, 32'h11, 32'h0,        32'h80F07F01, 2, 0, 32'h0000007F, 32'h10, 4'b0000, 32'h0,        4, 3);
        vecs[7]  = mk(1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0,        0, 0, 32'h0,        32'h20, 4'b1100, 32'hABCDABCD, 2, 1);
        vecs[8]  = mk(1, 3'b010, 32'h24, 32'hDEADBEEF, 32'h0,        3, 0, 32'h0,        32'h24, 4'b1111, 32'hDEADBEEF, 5, 4);
        vecs[9]  = mk(0, 3'b011, 32'h10, 32'h0,        32'h80F07F01, 0, 1, 32'h0,        32'h0,  4'b0000, 32'h0,        1, 0);
        vecs[10] = mk(1, 3'b100, 32'h10, 32'h55,       32'h0,        0, 1, 32'h0,        32'h0,  4'b0000, 32'h0,        1, 0);
        vecs[11] = mk(0, 3'b111, 32'h10, 32'h0,        32'h80F07F01, 0, 1, 32'h0,        32'h0,  4'b0000, 32'h0,        1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = mk(0, 3'b010, 32'h02, 32'h0,        32'h11223344, 0, 1, 32'h0,        32'h0,  4'b0000, 32'h0,        1, 0);
        vecs[13] = mk(0, 3'b001, 32'h13, 32'h0,        32'h80F07F01, 0, 1, 32'h0,        32'h0,  4'b0000, 32'h0,        1, 0);
`else
        vecs[12] = mk(0, 3'b010, 32'h02, 32'h0,        32'h11223344, 0, 0, 32'h11223344, 32'h0,  4'b0000, 32'h0,        2, 1);
        vecs[13] = mk(0, 3'b001, 32'h13, 32'h0,        32'h80F07F01, 0, 0, 32'hFFFF80F0, 32'h10, 4'b0000, 32'h0,        2, 1);
`endif
        vecs[14] = mk(0, 3'b010, 32'h30, 32'h0,        32'hCAFEF00D, 255, 1, 32'h0,      32'h30, 4'b0000, 32'h0,        5, 4);
        vecs[15] = mk(0, 3'b010, 32'h30, 32'h0,        32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 32'h30, 4'b0000, 32'h0,        2, 1);
        vecs[16] = mk(1, 3'b000, 32'h13, 32'h0000005A, 32'h0,        0, 0, 32'h0,        32'h10, 4'b1000, 32'h5A5A5A5A, 2, 1);

        // Reset values
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst strobes", 32'({mem_wstrobe, mem_rstrobe}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) run(i, vecs[i]);

        // Reset during a stalled ACCESS: strobe drops at once, no response appears.
        lat_cfg    = 255;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst strobe_before", 32'(mem_rstrobe), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst strobe_dropped", 32'({mem_wstrobe, mem_rstrobe}), 32'd0);
        chk("mid_rst ready_in_reset", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("mid_rst no_resp", 32'(seen), 32'd0);
        chk("mid_rst ready_after", 32'(req_ready), 32'd1);
        v = vecs[15];
        run(17, v);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
